decode_execute_register: RTL and testbench

// - ID/EX pipeline register of the pipelined core. Captures the decode-stage

---
 rtl/decode_execute_register.sv | 146 ++++++++++++++
 tb/tb_decode_execute_register.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_register.sv
// ID/EX pipeline register: holds decode-stage results for one cycle and
// presents them to execute. Flush inserts a bubble, stall holds the current
// contents, and a watchdog flags a stall that lasts too long.
// Optional feature: define BUBBLE_COUNT_EN to add the FlushCount/StallCount
// event counters.
module decode_execute_register #(
    parameter int N         = 24,
    parameter int R         = 4,
    parameter int MAX_STALL = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         StallE,
    input  logic         FlushE,
    input  logic         ValidD,
    input  logic [N-1:0] RD1D,
    input  logic [N-1:0] RD2D,
    input  logic [N-1:0] ExtImmD,
    input  logic [R-1:0] RdD,
    input  logic         RegWriteD,
    input  logic         MemWriteD,
    input  logic         MemtoRegD,
    input  logic         BranchD,
    input  logic         ALUSrcD,
    input  logic [3:0]   ALUControlD,
    output logic [N-1:0] RD1E,
    output logic [N-1:0] RD2E,
    output logic [N-1:0] ExtImmE,
    output logic [R-1:0] RdE,
    output logic         RegWriteE,
    output logic         MemWriteE,
    output logic         MemtoRegE,
    output logic         BranchE,
    output logic         ALUSrcE,
    output logic [3:0]   ALUControlE,
    output logic         ValidE,
`ifdef BUBBLE_COUNT_EN
    output logic [15:0]  FlushCount,
    output logic [15:0]  StallCount,
`endif
    output logic         StallTimeout
);

    // Counter must be able to hold MAX_STALL+1, where it saturates.
    localparam int            CW          = $clog2(MAX_STALL + 2);
    localparam logic [CW-1:0] STALL_LIMIT = CW'(MAX_STALL + 1);

    typedef struct packed {
        logic         valid;
        logic         regWrite;
        logic         memWrite;
        logic         memtoReg;
        logic         branch;
        logic         aluSrc;
        logic [3:0]   aluControl;
        logic [R-1:0] rd;
        logic [N-1:0] rd1;
        logic [N-1:0] rd2;
        logic [N-1:0] extImm;
    } stage_t;

    stage_t        stageQ;
    stage_t        captureD;
    logic [CW-1:0] stallCnt;
    logic          stallOnly;

    // A stall only counts when no flush overrides it on the same edge.
    assign stallOnly = StallE & ~FlushE;

    // Assemble the value captured on a free edge; side-effecting control
    // bits are squashed when the decode slot is empty.
    always_comb begin
        // NOTE: default the whole struct first so no path leaves a field unassigned (no latch).
        captureD            = '0;
        captureD.valid      = ValidD;
        captureD.regWrite   = RegWriteD & ValidD;
        captureD.memWrite   = MemWriteD & ValidD;
        captureD.memtoReg   = MemtoRegD;
        captureD.branch     = BranchD & ValidD;
        captureD.aluSrc     = ALUSrcD;
        captureD.aluControl = ALUControlD;
        captureD.rd         = RdD;
        captureD.rd1        = RD1D;
        captureD.rd2        = RD2D;
        captureD.extImm     = ExtImmD;
    end

    // Pipeline register: flush beats stall beats capture.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            stageQ <= '0;
        end else if (FlushE) begin
            stageQ <= '0;
        end else if (!StallE) begin
            stageQ <= captureD;
        end
    end

    // Stall watchdog: counts consecutive stall edges, sticky timeout flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt     <= '0;
            StallTimeout <= 1'b0;
        end else if (stallOnly) begin
            if (stallCnt != STALL_LIMIT) begin
                stallCnt <= stallCnt + CW'(1);
            end
            if (stallCnt >= STALL_LIMIT - CW'(1)) begin
                StallTimeout <= 1'b1;
            end
        end else begin
            stallCnt <= '0;
        end
    end

`ifdef BUBBLE_COUNT_EN
    // Saturating event counters for flushes and effective stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            FlushCount <= '0;
            StallCount <= '0;
        end else begin
            if (FlushE && FlushCount != 16'hFFFF) begin
                FlushCount <= FlushCount + 16'd1;
            end
            if (stallOnly && StallCount != 16'hFFFF) begin
                StallCount <= StallCount + 16'd1;
            end
        end
    end
`endif

    assign ValidE      = stageQ.valid;
    assign RegWriteE   = stageQ.regWrite;
    assign MemWriteE   = stageQ.memWrite;
    assign MemtoRegE   = stageQ.memtoReg;
    assign BranchE     = stageQ.branch;
    assign ALUSrcE     = stageQ.aluSrc;
    assign ALUControlE = stageQ.aluControl;
    assign RdE         = stageQ.rd;
    assign RD1E        = stageQ.rd1;
    assign RD2E        = stageQ.rd2;
    assign ExtImmE     = stageQ.extImm;

endmodule

// File: tb/tb_decode_execute_register.sv
// Self-checking bench for decode_execute_register: a behavioural model
// pushes the expected E-stage state per edge, which is popped and compared
// after the edge; directed cases plus a randomized run.
module tb_decode_execute_register;

    localparam int N         = 24;
    localparam int R         = 4;
    localparam int MAX_STALL = 15;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         StallE, FlushE, ValidD;
    logic [N-1:0] RD1D, RD2D, ExtImmD;
    logic [R-1:0] RdD;
    logic         RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD;
    logic [3:0]   ALUControlD;
    logic [N-1:0] RD1E, RD2E, ExtImmE;
    logic [R-1:0] RdE;
    logic         RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE;
    logic [3:0]   ALUControlE;
    logic         ValidE, StallTimeout;
`ifdef BUBBLE_COUNT_EN
    logic [15:0]  FlushCount, StallCount;
`endif

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic         valid;
        logic         regWrite;
        logic         memWrite;
        logic         memtoReg;
        logic         branch;
        logic         aluSrc;
        logic [3:0]   aluCtl;
        logic [R-1:0] rd;
        logic [N-1:0] rd1;
        logic [N-1:0] rd2;
        logic [N-1:0] imm;
        logic         timeout;
        logic [15:0]  fcnt;
        logic [15:0]  scnt;
    } exp_t;

    exp_t model;
    int   wdCnt;
    exp_t expQ[$];

    decode_execute_register #(.N(N), .R(R), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .rst_n(rst_n), .StallE(StallE), .FlushE(FlushE), .ValidD(ValidD),
        .RD1D(RD1D), .RD2D(RD2D), .ExtImmD(ExtImmD), .RdD(RdD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .MemtoRegD(MemtoRegD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .ALUControlD(ALUControlD),
        .RD1E(RD1E), .RD2E(RD2E), .ExtImmE(ExtImmE), .RdE(RdE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .MemtoRegE(MemtoRegE),
        .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
        .ValidE(ValidE),
`ifdef BUBBLE_COUNT_EN
        .FlushCount(FlushCount), .StallCount(StallCount),
`endif
        .StallTimeout(StallTimeout)
    );

    always #5 clk = ~clk;

    // Global time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic compareAll(input string tag, input exp_t e);
        check({tag, ".valid"},    32'(ValidE),       32'(e.valid));
        check({tag, ".regWrite"}, 32'(RegWriteE),    32'(e.regWrite));
        check({tag, ".memWrite"}, 32'(MemWriteE),    32'(e.memWrite));
        check({tag, ".memtoReg"}, 32'(MemtoRegE),    32'(e.memtoReg));
        check({tag, ".branch"},   32'(BranchE),      32'(e.branch));
        check({tag, ".aluSrc"},   32'(ALUSrcE),      32'(e.aluSrc));
        check({tag, ".aluCtl"},   32'(ALUControlE),  32'(e.aluCtl));
        check({tag, ".rd"},       32'(RdE),          32'(e.rd));
        check({tag, ".rd1"},      32'(RD1E),         32'(e.rd1));
        check({tag, ".rd2"},      32'(RD2E),         32'(e.rd2));
        check({tag, ".imm"},      32'(ExtImmE),      32'(e.imm));
        check({tag, ".timeout"},  32'(StallTimeout), 32'(e.timeout));
`ifdef BUBBLE_COUNT_EN
        check({tag, ".fcnt"},     32'(FlushCount),   32'(e.fcnt));
        check({tag, ".scnt"},     32'(StallCount),   32'(e.scnt));
`endif
    endtask

    // Advance the model for one edge using the current inputs, push the
    // prediction, take the edge, then pop and compare.
    task automatic stepEdge(input string tag);
        exp_t e;
        exp_t got;
        e = model;
        if (FlushE) begin
            e         = '0;
            e.timeout = model.timeout;
            e.fcnt    = model.fcnt;
            e.scnt    = model.scnt;
        end else if (!StallE) begin
            e.valid    = ValidD;
            e.regWrite = ValidD ? RegWriteD : 1'b0;
            e.memWrite = ValidD ? MemWriteD : 1'b0;
            e.branch   = ValidD ? BranchD : 1'b0;
            e.memtoReg = MemtoRegD;
            e.aluSrc   = ALUSrcD;
            e.aluCtl   = ALUControlD;
            e.rd       = RdD;
            e.rd1      = RD1D;
            e.rd2      = RD2D;
            e.imm      = ExtImmD;
        end
        if (StallE && !FlushE) begin
            if (wdCnt < MAX_STALL + 1) wdCnt++;
            if (wdCnt == MAX_STALL + 1) e.timeout = 1'b1;
            if (model.scnt != 16'hFFFF) e.scnt = model.scnt + 16'd1;
        end else begin
            wdCnt = 0;
        end
        if (FlushE && model.fcnt != 16'hFFFF) e.fcnt = model.fcnt + 16'd1;
        model = e;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            check({tag, ".queue"}, 32'(0), 32'(1));
        end else begin
            got = expQ.pop_front();
            compareAll(tag, got);
        end
    endtask

    task automatic clearInputs();
        StallE = 1'b0; FlushE = 1'b0; ValidD = 1'b0;
        RD1D = '0; RD2D = '0; ExtImmD = '0; RdD = '0;
        RegWriteD = 1'b0; MemWriteD = 1'b0; MemtoRegD = 1'b0;
        BranchD = 1'b0; ALUSrcD = 1'b0; ALUControlD = '0;
    endtask

    // Assert reset between edges and confirm outputs clear without an edge.
    task automatic doReset(input string tag);
        exp_t z;
        z = '0;
        rst_n = 1'b0;
        #2;
        compareAll(tag, z);
        model = '0;
        wdCnt = 0;
        expQ.delete();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        clearInputs();
        rst_n = 1'b0;
        model = '0;
        wdCnt = 0;
        #1;
        doReset("rst0");
        stepEdge("idle");

        // Capture a valid instruction.
        ValidD = 1'b1; ExtImmD = 24'h000001; RegWriteD = 1'b1; RdD = 4'h3;
        ALUControlD = 4'h5; RD2D = 24'h123456;
        stepEdge("cap");
        check("cap.immConst", 32'(ExtImmE), 32'h1);
        check("cap.rdConst", 32'(RdE), 32'h3);
        check("cap.validConst", 32'(ValidE), 32'h1);

        // Stall holds the previous capture.
        ExtImmD = 24'h00000A;
        stepEdge("stallLoad");
        ExtImmD = 24'h00000B; StallE = 1'b1;
        for (int i = 0; i < 3; i++) stepEdge("stallHold");
        check("stall.holdConst", 32'(ExtImmE), 32'hA);
        StallE = 1'b0;
        stepEdge("stallRelease");
        check("stall.releaseConst", 32'(ExtImmE), 32'hB);

        // Flush beats stall; the watchdog restarts afterwards.
        MemWriteD = 1'b1;
        stepEdge("preFlush");
        StallE = 1'b1;
        stepEdge("stallBeforeFlush");
        FlushE = 1'b1;
        stepEdge("flushStall");
        check("flush.validConst", 32'(ValidE), 32'h0);
        check("flush.immConst", 32'(ExtImmE), 32'h0);
        FlushE = 1'b0; StallE = 1'b0;

        // Invalid gating: side-effecting bits dropped, data still captured.
        ValidD = 1'b0; RegWriteD = 1'b1; MemWriteD = 1'b1; BranchD = 1'b1;
        MemtoRegD = 1'b1; ExtImmD = 24'h0000C3;
        stepEdge("invalid");
        check("invalid.regWriteConst", 32'(RegWriteE), 32'h0);
        check("invalid.immConst", 32'(ExtImmE), 32'hC3);

        // Watchdog from a clean reset: 15 stalls quiet, 16th trips it.
        doReset("rstWd");
        clearInputs();
        ValidD = 1'b1; ExtImmD = 24'h000077;
        stepEdge("wdLoad");
        StallE = 1'b1;
        for (int i = 0; i < MAX_STALL; i++) stepEdge("wdStall");
        check("wd.beforeTrip", 32'(StallTimeout), 32'h0);
        stepEdge("wdTrip");
        check("wd.tripConst", 32'(StallTimeout), 32'h1);
`ifdef BUBBLE_COUNT_EN
        check("wd.stallCount", 32'(StallCount), 32'd16);
        check("wd.flushCount", 32'(FlushCount), 32'd0);
`endif
        stepEdge("wdSaturate");
        StallE = 1'b0;
        stepEdge("wdDrop");
        check("wd.sticky", 32'(StallTimeout), 32'h1);
        FlushE = 1'b1;
        stepEdge("wdFlush");
        check("wd.flushKeeps", 32'(StallTimeout), 32'h1);
        FlushE = 1'b0;

        // Mid-run asynchronous reset clears everything before the next edge.
        RD1D = 24'hABCDEF;
        stepEdge("midLoad");
        check("mid.rd1Const", 32'(RD1E), 32'hABCDEF);
        doReset("rstMid");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            StallE      = ($urandom_range(0, 3) == 0);
            FlushE      = ($urandom_range(0, 7) == 0);
            ValidD      = ($urandom_range(0, 3) != 0);
            RD1D        = N'($urandom);
            RD2D        = N'($urandom);
            ExtImmD     = N'($urandom);
            RdD         = R'($urandom);
            RegWriteD   = 1'($urandom);
            MemWriteD   = 1'($urandom);
            MemtoRegD   = 1'($urandom);
            BranchD     = 1'($urandom);
            ALUSrcD     = 1'($urandom);
            ALUControlD = 4'($urandom);
            stepEdge("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
